wb_pad_ctrl: RTL and testbench
==============================

# wb_pad_ctrl

Wishbone-slave controller for the general-purpose bidirectional pads above the Caravel-owned range, replacing the hard-tied pad configuration in the chip core with software-programmable per-pad output, direction and electrical settings. It sits on the user Wishbone bus beside the eFuse memory. It adds features the fixed configuration lacks:

- input synchronisation,
- atomic set/clear of outputs,
- per-pad edge-triggered interrupts.

## Interface
- `NUM_PADS`, 16: number of controlled pads, 1..32.
- `BASE_ADR`, 32'h3000_1000: register block base; decode on `wbm_adr_i[31:8]`.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..3.

Ports (one clock; reset is synchronous and active-high):
- `wb_clk_i`  in  1  bus and block clock
- `wb_rst_i`  in  1  synchronous active-high reset
- `wbm_cyc_i`, `wbm_stb_i`, `wbm_we_i`  in  1  Wishbone classic controls
- `wbm_sel_i`  in  4  byte enables
- `wbm_adr_i`  in  32  byte address
- `wbm_dat_i`  in  32  write data
- `wbm_dat_o`  out  32  read data, valid while `wbm_ack_o`
- `wbm_ack_o`  out  1  single-cycle acknowledge
- `pad_in`  in  NUM_PADS  raw pad input, asynchronous
- `pad_out`, `pad_oe`, `pad_ie`, `pad_pu`, `pad_pd`, `pad_sl`, `pad_cs`  out  NUM_PADS  pad controls, registered
- `irq_o`  out  1  level interrupt, registered

## Operation
Register map (word offsets):
- 0x00 OUT, 0x04 OE, 0x08 IE, 0x0C PU, 0x10 PD, 0x14 SL, 0x18 CS.
- 0x1C IN: read-only, synchronised input.
- 0x20 RISE_EN, 0x24 FALL_EN.
- 0x28 STATUS: write-1-to-clear.
- 0x2C OUT_SET: write-1-to-set OUT, reads 0.
- 0x30 OUT_CLR: write-1-to-clear OUT, reads 0.
- Other offsets inside the block: read 0, writes ignored, still acked.
- Bits [31:NUM_PADS] read 0 and ignore writes.

Write rules:
- Writes honour `wbm_sel_i` per byte lane, including the W1C, W1S and W1C-OUT registers.

Pad output rules:
- `pad_pd` = PD & ~PU, so pull-up wins on conflict. Stored PD is unchanged and reads back as written.
- All other pad outputs equal their register bit directly.

Input and edge detection:
- `pad_in` passes through `SYNC_STAGES` flops, then one "previous" flop.
- rise = sync & ~prev; fall = ~sync & prev.
- STATUS[i] sets on (rise & RISE_EN[i]) | (fall & FALL_EN[i]).
- If a W1C write and a new edge hit the same bit in the same cycle, set wins.
- `irq_o` = |STATUS, registered.
- Clearing an enable does not clear pending STATUS.

Reset values:
- OUT, OE, PU, PD, SL, CS, RISE_EN, FALL_EN and STATUS are 0.
- IE is all-ones.
- Synchroniser and previous flops are 0.
- `wbm_ack_o`, `wbm_dat_o` and `irq_o` are 0.

## Timing
Bus handshake:
- An access is decoded when `wbm_cyc_i & wbm_stb_i & ~wbm_ack_o` and the address matches `BASE_ADR[31:8]`.
- `wbm_ack_o` asserts the next cycle for exactly one cycle; no wait states, no pipelining. Minimum two cycles per access.
- Non-matching addresses are never acked.
- The write takes effect on the ack cycle edge: the register and its pad output update together with ack high.
- Read data is registered: `wbm_dat_o` is valid only with ack and is 0 otherwise.

Input path latency:
- A `pad_in` change is visible in IN after `SYNC_STAGES` clocks.
- STATUS sets 1 clock after that; `irq_o` follows 1 clock later. With the default depth, edge to `irq_o` is 4 clocks.

Boundary conditions:
- Back-to-back OUT_SET then OUT_CLR on the same bit: each is applied in its own ack cycle, with no lost update.
- `wb_rst_i` mid-transaction: ack is 0 the next cycle, all state returns to reset values, and the access is dropped (master retries).
- A pad toggling every clock: each synchronised edge sets STATUS. STATUS is sticky; no edge counting.

## Structure
- Package `pad_ctrl_pkg`:
  - register offset localparams,
  - reset constants (IE all-ones),
  - the `reg_idx_e` enum of decoded registers.
- Sub-module `pad_in_sync`: `SYNC_STAGES`-deep synchroniser, previous flop and rise/fall outputs, instantiated once for the `NUM_PADS` vector.
- Top level holds the Wishbone decode, register file, pad output logic and interrupt logic.

## Test plan
- Reset, then read all registers: IE = 0x0000FFFF (NUM_PADS=16), all others 0, `irq_o` = 0, every pad output 0 except `pad_ie`.
- Write OUT = 0x00A5 with sel = 4'b0001, then sel = 4'b0010 with 0x3C00: OUT reads 0x3CA5, `pad_out` matches on each ack cycle.
- OUT = 0x00F0, OUT_SET = 0x0003, OUT_CLR = 0x0010: OUT reads 0x00E3; OUT_SET readback is 0.
- PU = PD = 0x0001: `pad_pu[0]` = 1, `pad_pd[0]` = 0, PD reads 0x0001.
- RISE_EN = 0x0004, raise `pad_in[2]`: STATUS = 0x0004 after 3 clocks, `irq_o` after 4. Write STATUS = 0x0004 in the same cycle as a second edge: bit stays set. Clearing it with no edge drops `irq_o` one clock later.
- Access 0x3000_2000: no ack. Assert `wb_rst_i` during an acked write: the register stays at its reset value and ack is 0.

Source files
------------

// File: rtl/pad_ctrl_pkg.sv
// rtl/pad_ctrl_pkg.sv - register map, reset constants and decode for wb_pad_ctrl
package pad_ctrl_pkg;

  localparam logic [7:0] OFF_OUT     = 8'h00;
  localparam logic [7:0] OFF_OE      = 8'h04;
  localparam logic [7:0] OFF_IE      = 8'h08;
  localparam logic [7:0] OFF_PU      = 8'h0C;
  localparam logic [7:0] OFF_PD      = 8'h10;
  localparam logic [7:0] OFF_SL      = 8'h14;
  localparam logic [7:0] OFF_CS      = 8'h18;
  localparam logic [7:0] OFF_IN      = 8'h1C;
  localparam logic [7:0] OFF_RISE_EN = 8'h20;
  localparam logic [7:0] OFF_FALL_EN = 8'h24;
  localparam logic [7:0] OFF_STATUS  = 8'h28;
  localparam logic [7:0] OFF_OUT_SET = 8'h2C;
  localparam logic [7:0] OFF_OUT_CLR = 8'h30;

  localparam logic [31:0] IE_RST  = 32'hFFFF_FFFF;
  localparam logic [31:0] REG_RST = 32'h0000_0000;

  typedef enum logic [3:0] {
    REG_OUT, REG_OE, REG_IE, REG_PU, REG_PD, REG_SL, REG_CS, REG_IN,
    REG_RISE_EN, REG_FALL_EN, REG_STATUS, REG_OUT_SET, REG_OUT_CLR, REG_NONE
  } reg_idx_e;

  function automatic reg_idx_e decode_reg(input logic [7:0] off);
    case (off)
      OFF_OUT:     return REG_OUT;
      OFF_OE:      return REG_OE;
      OFF_IE:      return REG_IE;
      OFF_PU:      return REG_PU;
      OFF_PD:      return REG_PD;
      OFF_SL:      return REG_SL;
      OFF_CS:      return REG_CS;
      OFF_IN:      return REG_IN;
      OFF_RISE_EN: return REG_RISE_EN;
      OFF_FALL_EN: return REG_FALL_EN;
      OFF_STATUS:  return REG_STATUS;
      OFF_OUT_SET: return REG_OUT_SET;
      OFF_OUT_CLR: return REG_OUT_CLR;
      default:     return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pad_in_sync.sv
// rtl/pad_in_sync.sv - multi-stage pad input synchroniser with rise/fall detect
module pad_in_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/wb_pad_ctrl.sv
// rtl/wb_pad_ctrl.sv - Wishbone slave for programmable GPIO pads with edge interrupts
module wb_pad_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int          NUM_PADS    = 16,
  parameter logic [31:0] BASE_ADR    = 32'h3000_1000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbm_cyc_i,
  input  logic                wbm_stb_i,
  input  logic                wbm_we_i,
  input  logic [3:0]          wbm_sel_i,
  input  logic [31:0]         wbm_adr_i,
  input  logic [31:0]         wbm_dat_i,
  output logic [31:0]         wbm_dat_o,
  output logic                wbm_ack_o,
  input  logic [NUM_PADS-1:0] pad_in,
  output logic [NUM_PADS-1:0] pad_out,
  output logic [NUM_PADS-1:0] pad_oe,
  output logic [NUM_PADS-1:0] pad_ie,
  output logic [NUM_PADS-1:0] pad_pu,
  output logic [NUM_PADS-1:0] pad_pd,
  output logic [NUM_PADS-1:0] pad_sl,
  output logic [NUM_PADS-1:0] pad_cs,
  output logic                irq_o
);

  typedef logic [NUM_PADS-1:0] pads_t;

  pads_t out_q, oe_q, ie_q, pu_q, pd_q, sl_q, cs_q, rise_en_q, fall_en_q, status_q, pad_pd_q;
  pads_t out_d, oe_d, ie_d, pu_d, pd_d, sl_d, cs_d, rise_en_d, fall_en_d, status_d;
  logic [31:0] dat_q, dat_d;
  logic        ack_q, irq_q;

  pads_t    in_sync, in_rise, in_fall, wm, wdat, wbits, edge_set, rd_val;
  logic [31:0] lane_mask;
  logic     acc, wr;
  reg_idx_e idx;

  pad_in_sync #(.WIDTH(NUM_PADS), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .pad_i  (pad_in),
    .sync_o (in_sync),
    .rise_o (in_rise),
    .fall_o (in_fall)
  );

  function automatic pads_t merge(input pads_t q, input pads_t d, input pads_t m);
    return (q & ~m) | (d & m);
  endfunction

  assign lane_mask = {{8{wbm_sel_i[3]}}, {8{wbm_sel_i[2]}}, {8{wbm_sel_i[1]}}, {8{wbm_sel_i[0]}}};
  assign wm        = lane_mask[NUM_PADS-1:0];
  assign wdat      = wbm_dat_i[NUM_PADS-1:0];
  assign wbits     = wdat & wm;

  if (NUM_PADS < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^{wbm_dat_i[31:NUM_PADS], lane_mask[31:NUM_PADS]};
  end

  always_comb begin
    acc       = wbm_cyc_i & wbm_stb_i & ~ack_q & (wbm_adr_i[31:8] == BASE_ADR[31:8]);
    wr        = acc & wbm_we_i;
    idx       = decode_reg(wbm_adr_i[7:0]);
    edge_set  = (in_rise & rise_en_q) | (in_fall & fall_en_q);
    out_d     = out_q;
    oe_d      = oe_q;
    ie_d      = ie_q;
    pu_d      = pu_q;
    pd_d      = pd_q;
    sl_d      = sl_q;
    cs_d      = cs_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    // new edges are OR-ed in after the W1C so a simultaneous set wins
    status_d  = status_q | edge_set;
    if (wr) begin
      case (idx)
        REG_OUT:     out_d     = merge(out_q, wdat, wm);
        REG_OE:      oe_d      = merge(oe_q, wdat, wm);
        REG_IE:      ie_d      = merge(ie_q, wdat, wm);
        REG_PU:      pu_d      = merge(pu_q, wdat, wm);
        REG_PD:      pd_d      = merge(pd_q, wdat, wm);
        REG_SL:      sl_d      = merge(sl_q, wdat, wm);
        REG_CS:      cs_d      = merge(cs_q, wdat, wm);
        REG_RISE_EN: rise_en_d = merge(rise_en_q, wdat, wm);
        REG_FALL_EN: fall_en_d = merge(fall_en_q, wdat, wm);
        REG_STATUS:  status_d  = (status_q & ~wbits) | edge_set;
        REG_OUT_SET: out_d     = out_q | wbits;
        REG_OUT_CLR: out_d     = out_q & ~wbits;
        default:     ;
      endcase
    end
    case (idx)
      REG_OUT:     rd_val = out_q;
      REG_OE:      rd_val = oe_q;
      REG_IE:      rd_val = ie_q;
      REG_PU:      rd_val = pu_q;
      REG_PD:      rd_val = pd_q;
      REG_SL:      rd_val = sl_q;
      REG_CS:      rd_val = cs_q;
      REG_IN:      rd_val = in_sync;
      REG_RISE_EN: rd_val = rise_en_q;
      REG_FALL_EN: rd_val = fall_en_q;
      REG_STATUS:  rd_val = status_q;
      default:     rd_val = '0;
    endcase
    dat_d = '0;
    if (acc && !wbm_we_i) dat_d[NUM_PADS-1:0] = rd_val;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_q     <= REG_RST[NUM_PADS-1:0];
      oe_q      <= REG_RST[NUM_PADS-1:0];
      ie_q      <= IE_RST[NUM_PADS-1:0];
      pu_q      <= REG_RST[NUM_PADS-1:0];
      pd_q      <= REG_RST[NUM_PADS-1:0];
      sl_q      <= REG_RST[NUM_PADS-1:0];
      cs_q      <= REG_RST[NUM_PADS-1:0];
      rise_en_q <= REG_RST[NUM_PADS-1:0];
      fall_en_q <= REG_RST[NUM_PADS-1:0];
      status_q  <= REG_RST[NUM_PADS-1:0];
      pad_pd_q  <= REG_RST[NUM_PADS-1:0];
      dat_q     <= '0;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      ie_q      <= ie_d;
      pu_q      <= pu_d;
      pd_q      <= pd_d;
      sl_q      <= sl_d;
      cs_q      <= cs_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      pad_pd_q  <= pd_d & ~pu_d;
      dat_q     <= dat_d;
      ack_q     <= acc;
      irq_q     <= |status_q;
    end
  end

  assign wbm_dat_o = dat_q;
  assign wbm_ack_o = ack_q;
  assign irq_o     = irq_q;
  assign pad_out   = out_q;
  assign pad_oe    = oe_q;
  assign pad_ie    = ie_q;
  assign pad_pu    = pu_q;
  assign pad_pd    = pad_pd_q;
  assign pad_sl    = sl_q;
  assign pad_cs    = cs_q;

endmodule

// File: tb/tb_wb_pad_ctrl.sv
// tb/tb_wb_pad_ctrl.sv - directed scoreboard bench for wb_pad_ctrl
module tb_wb_pad_ctrl;

  localparam logic [31:0] BASE = 32'h3000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic [31:0] dat_o;
  logic        ack, irq;
  logic [15:0] pad_in = '0;
  logic [15:0] pad_out, pad_oe, pad_ie, pad_pu, pad_pd, pad_sl, pad_cs;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  wb_pad_ctrl dut (
    .wb_clk_i (clk),    .wb_rst_i (rst),
    .wbm_cyc_i(cyc),    .wbm_stb_i(stb),    .wbm_we_i(we),
    .wbm_sel_i(sel),    .wbm_adr_i(adr),    .wbm_dat_i(wdat),
    .wbm_dat_o(dat_o),  .wbm_ack_o(ack),
    .pad_in   (pad_in),
    .pad_out  (pad_out), .pad_oe(pad_oe), .pad_ie(pad_ie), .pad_pu(pad_pu),
    .pad_pd   (pad_pd),  .pad_sl(pad_sl), .pad_cs(pad_cs),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s, input string tag);
    cyc = 1; stb = 1; we = 1; sel = s; adr = BASE + {24'h0, off}; wdat = d;
    tick();
    chk({tag, " ack"}, {31'h0, ack}, 32'h1);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_idle();
    tick();
  endtask

  task automatic wb_read(input logic [7:0] off, input logic [31:0] expv, input string tag);
    logic [31:0] e;
    exp_q.push_back(expv);
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = BASE + {24'h0, off};
    tick();
    chk({tag, " ack"}, {31'h0, ack}, 32'h1);
    e = exp_q.pop_front();
    if (ack) chk(tag, dat_o, e);
    cyc = 0; stb = 0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 0;
    chk("rst ack", {31'h0, ack}, 32'h0);
    chk("rst dat", dat_o, 32'h0);
    chk("rst irq", {31'h0, irq}, 32'h0);
    chk("rst pad_out", {16'h0, pad_out}, 32'h0);
    chk("rst pad_oe", {16'h0, pad_oe}, 32'h0);
    chk("rst pad_ie", {16'h0, pad_ie}, 32'h0000_FFFF);
    chk("rst pad_pu", {16'h0, pad_pu}, 32'h0);
    chk("rst pad_pd", {16'h0, pad_pd}, 32'h0);
    chk("rst pad_sl", {16'h0, pad_sl}, 32'h0);
    chk("rst pad_cs", {16'h0, pad_cs}, 32'h0);
    for (int i = 0; i <= 12; i++) begin
      logic [7:0] off;
      off = 8'(i * 4);
      wb_read(off, (off == 8'h08) ? 32'h0000_FFFF : 32'h0, $sformatf("rst reg %02h", off));
    end
    chk("dat idle", dat_o, 32'h0);

    wb_write(8'h00, 32'h1234_56A5, 4'b0001, "out lane0");
    chk("pad_out lane0", {16'h0, pad_out}, 32'h0000_00A5);
    wb_idle();
    wb_write(8'h00, 32'h0000_3C00, 4'b0010, "out lane1");
    chk("pad_out lane1", {16'h0, pad_out}, 32'h0000_3CA5);
    wb_idle();
    wb_read(8'h00, 32'h0000_3CA5, "out rd");

    wb_write(8'h00, 32'h0000_00F0, 4'hF, "out f0");
    wb_idle();
    wb_write(8'h2C, 32'h0000_0003, 4'hF, "out_set");
    chk("pad_out set", {16'h0, pad_out}, 32'h0000_00F3);
    wb_idle();
    wb_write(8'h30, 32'h0000_0010, 4'hF, "out_clr");
    chk("pad_out clr", {16'h0, pad_out}, 32'h0000_00E3);
    wb_idle();
    wb_write(8'h2C, 32'h0000_0100, 4'b0001, "out_set lane");
    chk("pad_out set lane", {16'h0, pad_out}, 32'h0000_00E3);
    wb_idle();
    wb_read(8'h00, 32'h0000_00E3, "out rd2");
    wb_read(8'h2C, 32'h0, "out_set rd");
    wb_read(8'h30, 32'h0, "out_clr rd");

    wb_write(8'h0C, 32'h1, 4'hF, "pu");
    wb_idle();
    wb_write(8'h10, 32'h1, 4'hF, "pd");
    chk("pad_pu conflict", {16'h0, pad_pu}, 32'h1);
    chk("pad_pd conflict", {16'h0, pad_pd}, 32'h0);
    wb_idle();
    wb_read(8'h10, 32'h1, "pd rd");
    wb_write(8'h0C, 32'h0, 4'hF, "pu off");
    chk("pad_pd released", {16'h0, pad_pd}, 32'h1);
    wb_idle();

    wb_write(8'h04, 32'hFFFF_FFFF, 4'hF, "oe all");
    chk("pad_oe all", {16'h0, pad_oe}, 32'h0000_FFFF);
    wb_idle();
    wb_read(8'h04, 32'h0000_FFFF, "oe rd upper");

    wb_write(8'h20, 32'h4, 4'hF, "rise_en");
    wb_idle();
    pad_in[2] = 1'b1;
    repeat (3) tick();
    chk("irq at 3", {31'h0, irq}, 32'h0);
    tick();
    chk("irq at 4", {31'h0, irq}, 32'h1);
    wb_read(8'h28, 32'h4, "status rise");
    wb_read(8'h1C, 32'h4, "in rd");

    pad_in[2] = 1'b0;
    repeat (5) tick();
    pad_in[2] = 1'b1;
    repeat (2) tick();
    wb_write(8'h28, 32'h4, 4'hF, "w1c vs edge");
    wb_idle();
    wb_read(8'h28, 32'h4, "status set wins");
    chk("irq held", {31'h0, irq}, 32'h1);

    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = BASE + 32'h28; wdat = 32'h4;
    tick();
    chk("w1c ack", {31'h0, ack}, 32'h1);
    chk("irq on clear", {31'h0, irq}, 32'h1);
    cyc = 0; stb = 0; we = 0;
    tick();
    chk("irq cleared", {31'h0, irq}, 32'h0);
    wb_read(8'h28, 32'h0, "status cleared");

    wb_write(8'h24, 32'h8, 4'hF, "fall_en");
    wb_idle();
    pad_in[3] = 1'b1;
    repeat (5) tick();
    pad_in[3] = 1'b0;
    repeat (5) tick();
    wb_write(8'h24, 32'h0, 4'hF, "fall_en off");
    wb_idle();
    wb_read(8'h28, 32'h8, "status sticky");
    chk("irq fall", {31'h0, irq}, 32'h1);

    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3000_2000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("miss no ack %0d", i), {31'h0, ack}, 32'h0);
    end
    cyc = 0; stb = 0;
    tick();

    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = BASE + 32'h0C; wdat = 32'h5;
    rst = 1;
    tick();
    chk("rst mid ack", {31'h0, ack}, 32'h0);
    chk("rst mid pu", {16'h0, pad_pu}, 32'h0);
    chk("rst mid oe", {16'h0, pad_oe}, 32'h0);
    chk("rst mid ie", {16'h0, pad_ie}, 32'h0000_FFFF);
    chk("rst mid irq", {31'h0, irq}, 32'h0);
    cyc = 0; stb = 0; we = 0;
    rst = 0;
    pad_in = '0;
    tick();
    wb_read(8'h0C, 32'h0, "pu after rst");
    wb_read(8'h28, 32'h0, "status after rst");
    chk("queue drained", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
